// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART ALU datapath: controller states,
// default framing parameters and the opcode map used by the ALU.
package uart_alu_pkg;

  localparam int OP_W_DEF    = 6;
  localparam int GAP_CYC_DEF = 100000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  // MIPS-style function codes understood by the ALU
  localparam logic [OP_W_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [OP_W_DEF-1:0] OP_AND = 6'h24;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [OP_W_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [OP_W_DEF-1:0] OP_NOR = 6'h27;
  localparam logic [OP_W_DEF-1:0] OP_SRA = 6'h03;
  localparam logic [OP_W_DEF-1:0] OP_SRL = 6'h02;

endpackage

// File: rtl/gap_timer.sv
// Inter-byte idle counter; saturates once GAP_CYC-1 is reached so a stalled
// frame keeps reporting expiry until the controller clears it.
module gap_timer
  import uart_alu_pkg::*;
#(
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [W-1:0] LIMIT = W'(GAP_CYC - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && (count != LIMIT))
      count <= count + 1'b1;
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/alu_frame_ctrl.sv
// Collects A/B/Op bytes from the UART receiver, drives the ALU operands,
// captures the result and hands it to the UART transmitter.
module alu_frame_ctrl
  import uart_alu_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int OP_W    = OP_W_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] rx_dout,
  output logic [DBIT-1:0] alu_a,
  output logic [DBIT-1:0] alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [DBIT-1:0] alu_result,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_din,
  input  logic            tx_done_tick,
  output logic            busy,
  output logic            frame_err,
  output logic            drop_tick
);

  state_t state, state_next;
  logic   accept, timer_en, timer_expired;

  gap_timer #(.GAP_CYC(GAP_CYC)) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // A byte arriving on the timeout cycle wins over the timeout
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (rx_done_tick) state_next = ST_GET_B;
      ST_GET_B:   if (rx_done_tick) state_next = ST_GET_OP;
                  else if (timer_expired) state_next = ST_IDLE;
      ST_GET_OP:  if (rx_done_tick) state_next = ST_EXEC;
                  else if (timer_expired) state_next = ST_IDLE;
      ST_EXEC:    state_next = ST_SEND;
      ST_SEND:    state_next = ST_WAIT_TX;
      ST_WAIT_TX: if (tx_done_tick) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    timer_en  = 1'b0;
    tx_start  = 1'b0;
    frame_err = 1'b0;
    drop_tick = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: accept = rx_dout_valid_idle();
        ST_GET_B, ST_GET_OP: begin
          accept    = rx_done_tick;
          timer_en  = 1'b1;
          frame_err = timer_expired && !rx_done_tick;
        end
        ST_SEND: begin
          tx_start  = 1'b1;
          drop_tick = rx_done_tick;
        end
        ST_EXEC, ST_WAIT_TX: drop_tick = rx_done_tick;
        default: ;
      endcase
    end
  end

  function automatic logic rx_dout_valid_idle();
    return rx_done_tick;
  endfunction

  // Operands hold until overwritten so the ALU sees stable inputs after a timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      tx_din <= '0;
      busy   <= 1'b0;
    end else begin
      if (accept) begin
        case (state)
          ST_IDLE:   alu_a  <= rx_dout;
          ST_GET_B:  alu_b  <= rx_dout;
          ST_GET_OP: alu_op <= rx_dout[OP_W-1:0];
          default: ;
        endcase
      end
      if (state == ST_EXEC)
        tx_din <= alu_result;
      busy <= (state_next != ST_IDLE);
    end
  end

endmodule
